// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared constants and types for the fully-connected classifier datapath.
// Used by the argmax final stage and by the GEMM controller.
//   DATA_WIDTH      signed width of scores, biases and results
//   OUTPUT_CHANNEL  number of classes produced per run
//   IDX_WIDTH       width of a class index
//   CNT_WIDTH       width of a beat counter that can hold OUTPUT_CHANNEL itself
//   SAT_MAX/SAT_MIN clamp limits for DATA_WIDTH signed arithmetic
//   fc_state_e      run-phase FSM encoding
// -----------------------------------------------------------------------------
package fc_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int OUTPUT_CHANNEL = 10;
  localparam int IDX_WIDTH      = 4;
  localparam int CNT_WIDTH      = $clog2(OUTPUT_CHANNEL + 1);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fc_sat_add.sv
// -----------------------------------------------------------------------------
// fc_sat_add
// Combinational signed add with saturation to the DATA_WIDTH signed range.
//   a_i, b_i  signed operands
//   sum_o     a_i + b_i clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1]
// -----------------------------------------------------------------------------
module fc_sat_add #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] sum_o
);

  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH:0] wide;

  always_comb begin
    // One guard bit cannot overflow; a disagreement between the top two bits
    // means the true sum left the DATA_WIDTH range, and the guard bit gives
    // the direction.
    wide = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      sum_o = wide[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
    end else begin
      sum_o = wide[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// -----------------------------------------------------------------------------
// fc_argmax
// Final classifier stage: streams OUTPUT_CHANNEL scores, adds each channel's
// bias with saturation, and reports the index and value of the largest result.
//   clk, reset_n   clock, asynchronous active-low reset
//   start          begin a run (honoured only in IDLE); latches bias
//   bias           packed per-channel biases, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_valid/s_ready/s_data  score stream, channel order 0..OUTPUT_CHANNEL-1
//   busy           run in progress (RUN or DRAIN)
//   done           one-cycle pulse, number/max_value are final
//   number         winning class index (running best while busy)
//   max_value      biased, saturated score of the winner
// -----------------------------------------------------------------------------
module fc_argmax
  import fc_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [DATA_WIDTH*OUTPUT_CHANNEL-1:0] bias,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic signed [DATA_WIDTH-1:0]         s_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [IDX_WIDTH-1:0]                 number,
  output logic signed [DATA_WIDTH-1:0]         max_value
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(OUTPUT_CHANNEL);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OUTPUT_CHANNEL - 1);

  fc_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]                 cnt_q;
  logic [DATA_WIDTH*OUTPUT_CHANNEL-1:0] bias_q;
  logic signed [DATA_WIDTH-1:0]         bias_sel;
  logic signed [DATA_WIDTH-1:0]         sum_d;

  logic                                 s1_valid_q;
  logic signed [DATA_WIDTH-1:0]         s1_sum_q;
  logic [IDX_WIDTH-1:0]                 s1_tag_q;

  logic [IDX_WIDTH-1:0]                 number_q;
  logic signed [DATA_WIDTH-1:0]         max_q;

  logic start_accept;
  logic beat_accept;
  logic last_accept;

  assign s_ready      = (state_q == RUN) && (cnt_q < CNT_FULL);
  assign beat_accept  = s_valid && s_ready;
  assign last_accept  = beat_accept && (cnt_q == CNT_LAST);
  assign start_accept = start && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Stage 1 empty means the last sum has reached the max registers.
        if (!s1_valid_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bias select and saturating add
  // ---------------------------------------------------------------------------
  always_comb begin
    bias_sel = '0;
    for (int k = 0; k < OUTPUT_CHANNEL; k++) begin
      if (cnt_q == CNT_WIDTH'(k)) bias_sel = bias_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  fc_sat_add #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_add (
    .a_i  (s_data),
    .b_i  (bias_sel),
    .sum_o(sum_d)
  );

  // ---------------------------------------------------------------------------
  // Beat counter, bias register, stage 1 (sum) and stage 2 (running max)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      // NOTE: the bias register is a plain flop bank, not a RAM, so it can
      // and does take the reset; an aborted run leaves no stale biases.
      bias_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_tag_q   <= '0;
      number_q   <= '0;
      max_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments here; every register samples the
      // pre-edge values of the others, which is what makes this a pipeline.
      s1_valid_q <= beat_accept;
      if (start_accept) begin
        bias_q   <= bias;
        cnt_q    <= '0;
        number_q <= '0;
        max_q    <= SAT_MIN;
      end else begin
        // s_ready already gates on cnt_q < OUTPUT_CHANNEL, so cnt saturates.
        if (beat_accept) begin
          cnt_q    <= cnt_q + 1'b1;
          s1_sum_q <= sum_d;
          s1_tag_q <= IDX_WIDTH'(cnt_q);
        end
        // Strict greater-than keeps the lowest index on ties; the first beat
        // always loads so a run of all-minimum values still reports channel 0.
        if (s1_valid_q && ((s1_tag_q == '0) || (s1_sum_q > max_q))) begin
          max_q    <= s1_sum_q;
          number_q <= s1_tag_q;
        end
      end
    end
  end

  assign number    = number_q;
  assign max_value = max_q;

endmodule

// File: tb/tb_fc_argmax.sv
module tb_fc_argmax;
  import fc_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int OC = OUTPUT_CHANNEL;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    start;
  logic [DW*OC-1:0]        bias;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [DW-1:0]    s_data;
  logic                    busy;
  logic                    done;
  logic [IDX_WIDTH-1:0]    number;
  logic signed [DW-1:0]    max_value;

  fc_argmax dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bias     (bias),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .busy     (busy),
    .done     (done),
    .number   (number),
    .max_value(max_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int num;
    int val;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  int               sc_arr   [OC];
  int               bias_arr [OC];
  logic [DW*OC-1:0] bias_v;
  logic [DW*OC-1:0] alt_bias_v;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_bias();
    for (int k = 0; k < OC; k++) bias_v[k*DW +: DW] = DW'(bias_arr[k]);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation,
  // including the cycle it was due.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_number", int'(number), e.num);
        check("done_max_value", int'(max_value), e.val);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // One run: start with bias_v, stream sc_arr with 'gap' idle cycles before
  // each beat. start_mid pulses start (with alt bias on the bus) mid-run;
  // abort_at>0 pulls reset after that many accepted beats.
  task automatic run_case(input string name, input int gap, input bit start_mid,
                          input int abort_at, input int exp_num, input int exp_val);
    int n;
    int acc_cyc;
    @(posedge clk); #1;
    bias  = bias_v;
    start = 1'b1;
    @(negedge clk);
    check({name, "/idle_s_ready"}, int'(s_ready), 0);
    check({name, "/idle_busy"}, int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    bias  = alt_bias_v;
    check({name, "/busy_after_start"}, int'(busy), 1);
    for (int k = 0; k < OC; k++) begin
      repeat (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = DW'(sc_arr[k]);
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) begin
        checks++;
        failures++;
        $display("FAIL %s/beat_timeout: got s_ready=0 for 20 cycles at beat %0d expected 1", name, k);
        s_valid = 1'b0;
        return;
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      if (k == OC - 1) sb_q.push_back('{exp_num, exp_val, acc_cyc + 3});
      start = (start_mid && k == 4);
      if (abort_at == k + 1) begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        check({name, "/abort_number"}, int'(number), 0);
        check({name, "/abort_max_value"}, int'(max_value), 0);
        check({name, "/abort_busy"}, int'(busy), 0);
        check({name, "/abort_s_ready"}, int'(s_ready), 0);
        check({name, "/abort_done"}, int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
    end
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'sd100;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check({name, "/extra_beat_s_ready"}, int'(s_ready), 0);
    end
    s_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s/done_timeout: got no done within 10 cycles expected a pulse", name);
      sb_q.delete();
    end
    @(negedge clk);
    check({name, "/held_number"}, int'(number), exp_num);
    check({name, "/held_max_value"}, int'(max_value), exp_val);
    check({name, "/idle_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    bias    = '0;
    for (int k = 0; k < OC; k++) alt_bias_v[k*DW +: DW] = 8'sd50;
    repeat (2) @(negedge clk);
    check("reset_s_ready", int'(s_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_number", int'(number), 0);
    check("reset_max_value", int'(max_value), 0);
    reset_n = 1'b1;

    // T1 basic
    sc_arr   = '{3, -1, 7, 2, 0, 0, 0, 0, 0, 0};
    bias_arr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_bias();
    run_case("T1", 0, 1'b0, 0, 2, 7);

    // T2 positive saturation and tie -> lowest index
    sc_arr   = '{120, 0, 0, 0, 0, 127, 0, 0, 0, 0};
    bias_arr = '{20, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_bias();
    run_case("T2", 0, 1'b0, 0, 0, 127);

    // T3 negative clamp, all equal
    sc_arr   = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    bias_arr = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    load_bias();
    run_case("T3", 0, 1'b0, 0, 0, -128);

    // T4 backpressure: valid pattern 1,0,0,1,...
    sc_arr   = '{3, -1, 7, 2, 0, 0, 0, 0, 0, 0};
    bias_arr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_bias();
    run_case("T4", 2, 1'b0, 0, 2, 7);

    // T5 reset after 4 accepts, then a clean T1 run
    run_case("T5a", 0, 1'b0, 4, 0, 0);
    run_case("T5b", 0, 1'b0, 0, 2, 7);

    // T6 start pulse mid-run with different bias on the bus
    bias_arr = '{0, 0, 0, 10, 0, 0, 0, 0, 0, 0};
    load_bias();
    run_case("T6", 1, 1'b1, 0, 3, 12);

    // T7 all negative, later channel wins
    sc_arr   = '{-100, -50, -60, -10, -20, -25, -35, -65, -75, -85};
    bias_arr = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
    load_bias();
    run_case("T7", 0, 1'b0, 0, 3, -15);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 expected earlier");
    $fatal(1, "timeout");
  end

endmodule
